// File: rtl/stream_pool_pkg.sv
// Shared definitions for the stream_pool 2x2 max-pooling block:
// configuration register addresses and the row-parity state encoding.
package stream_pool_pkg;

    localparam int CFG_WIDTH   = 1;
    localparam int CFG_KERNEL  = 2;
    localparam int CFG_RESCALE = 3;

    localparam logic [0:0] ST_EVEN = 1'b0;
    localparam logic [0:0] ST_ODD  = 1'b1;

endpackage

// File: rtl/stream_pool_mem.sv
// Single-port line memory holding one pooled value per horizontal pair of
// the previous (even) row; synchronous read, 1-cycle latency.
module stream_pool_mem
    import stream_pool_pkg::*;
#(
    parameter int MEM_AWIDTH = 8,
    parameter int MEM_DEPTH  = 128,
    parameter int IMG_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        we_i,
    input  logic                        re_i,
    input  logic [MEM_AWIDTH-1:0]       addr_i,
    input  logic signed [IMG_WIDTH-1:0] wdata_i,
    output logic signed [IMG_WIDTH-1:0] rdata_o
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [MEM_AWIDTH:0] DEPTH_L = (MEM_AWIDTH + 1)'(MEM_DEPTH);

    logic signed [IMG_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic                        in_range;
    logic [IDX_W-1:0]            idx;

    // Out-of-range addresses are ignored rather than aliased onto real entries.
    assign in_range = ({1'b0, addr_i} < DEPTH_L);
    assign idx      = addr_i[IDX_W-1:0];

    // Read data holds between reads so ODD-row gaps keep the fetched value.
    always_ff @(posedge clk) begin
        if (we_i && in_range) begin
            mem_q[idx] <= wdata_i;
        end else if (re_i && in_range) begin
            rdata_o <= mem_q[idx];
        end
    end

endmodule

// File: rtl/stream_pool.sv
// 2x2 stride-2 signed max pooling over a raster stream of configurable row
// width; even rows are pair-reduced into line memory, odd rows finish the max.
module stream_pool
    import stream_pool_pkg::*;
#(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int MEM_AWIDTH = 8,
    parameter int MEM_DEPTH  = 128,
    parameter int IMG_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CFG_DWIDTH-1:0]       cfg_data,
    input  logic [CFG_AWIDTH-1:0]       cfg_addr,
    input  logic                        cfg_valid,
    input  logic signed [IMG_WIDTH-1:0] image,
    input  logic                        image_val,
    output logic signed [IMG_WIDTH-1:0] result,
    output logic                        result_val
);

    localparam int WW = MEM_AWIDTH + 1;
    localparam logic [MEM_AWIDTH:0] MAX_W = WW'(2 * MEM_DEPTH);

    function automatic logic [MEM_AWIDTH:0] sat_width(input logic [MEM_AWIDTH:0] v);
        return (v > MAX_W) ? MAX_W : v;
    endfunction

    function automatic logic signed [IMG_WIDTH-1:0] smax(
        input logic signed [IMG_WIDTH-1:0] a,
        input logic signed [IMG_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic [MEM_AWIDTH:0]         w_q, w_d;
    logic [MEM_AWIDTH:0]         col_q, col_d;
    logic [0:0]                  state_q, state_d;
    logic signed [IMG_WIDTH-1:0] result_q, result_d;
    logic                        result_val_q, result_val_d;
    logic signed [IMG_WIDTH-1:0] pix_q;

    logic                        cfg_wr;
    logic                        accept;
    logic                        col_last;
    logic                        col_odd;
    logic                        mem_we;
    logic                        mem_re;
    logic [MEM_AWIDTH-1:0]       mem_addr;
    logic signed [IMG_WIDTH-1:0] mem_wdata;
    logic signed [IMG_WIDTH-1:0] mem_rdata;
    logic                        unused_cfg;

    assign unused_cfg = ^cfg_data[CFG_DWIDTH-1:MEM_AWIDTH+1];

    // A width write wins over a coincident sample, which is dropped.
    assign cfg_wr   = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_WIDTH));
    assign accept   = image_val && !cfg_wr && (w_q >= WW'(2));
    assign col_last = (col_q == w_q - WW'(1));
    assign col_odd  = col_q[0];

    assign mem_addr  = col_q[MEM_AWIDTH:1];
    assign mem_wdata = smax(pix_q, image);
    assign mem_we    = accept && (state_q == ST_EVEN) && col_odd;
    // The trailing pixel of an odd-width row has no partner and is skipped.
    assign mem_re    = accept && (state_q == ST_ODD) && !col_odd && !col_last;

    stream_pool_mem #(
        .MEM_AWIDTH (MEM_AWIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IMG_WIDTH  (IMG_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        w_d          = w_q;
        col_d        = col_q;
        state_d      = state_q;
        result_d     = result_q;
        result_val_d = 1'b0;
        if (cfg_wr) begin
            w_d     = sat_width(cfg_data[MEM_AWIDTH:0]);
            col_d   = '0;
            state_d = ST_EVEN;
        end else if (accept) begin
            col_d = col_last ? '0 : col_q + WW'(1);
            if (col_last) begin
                state_d = ~state_q;
            end
            if ((state_q == ST_ODD) && col_odd) begin
                result_val_d = 1'b1;
                result_d     = smax(mem_rdata, smax(pix_q, image));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q          <= '0;
            col_q        <= '0;
            state_q      <= ST_EVEN;
            result_q     <= '0;
            result_val_q <= 1'b0;
        end else begin
            w_q          <= w_d;
            col_q        <= col_d;
            state_q      <= state_d;
            result_q     <= result_d;
            result_val_q <= result_val_d;
        end
    end

    // First pixel of each pair; pure datapath, no reset needed.
    always_ff @(posedge clk) begin
        if (accept && !col_odd) begin
            pix_q <= image;
        end
    end

    assign result     = result_q;
    assign result_val = result_val_q;

endmodule

// File: tb/tb_stream_pool.sv
// Self-checking bench for stream_pool: directed scenarios plus randomized
// traffic, compared every cycle against a row-buffer reference model.
module tb_stream_pool;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        cfg_data;
    logic [4:0]         cfg_addr;
    logic               cfg_valid;
    logic signed [15:0] image;
    logic               image_val;
    logic signed [15:0] result;
    logic               result_val;

    int checks = 0;
    int errors = 0;
    int dut_results = 0;

    int   mW, mcol, mpar;
    int   rowA [256];
    int   rowB [256];
    logic exp_val;
    int   exp_res;

    stream_pool dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_data   (cfg_data),
        .cfg_addr   (cfg_addr),
        .cfg_valid  (cfg_valid),
        .image      (image),
        .image_val  (image_val),
        .result     (result),
        .result_val (result_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        mW = 0; mcol = 0; mpar = 0;
        exp_val = 1'b0;
        exp_res = 0;
    endtask

    // Reference: keep both rows of the current pair, pool 2x2 windows directly.
    task automatic model_update(input logic iv, input int d, input logic cv,
                                input int ca, input int cd);
        int wv;
        logic [15:0] d16;
        int sv;
        exp_val = 1'b0;
        if (cv && ca == 1) begin
            wv = cd & 511;
            mW = (wv > 256) ? 256 : wv;
            mcol = 0;
            mpar = 0;
            return;
        end
        if (!iv || mW < 2) return;
        d16 = d[15:0];
        sv = int'($signed(d16));
        if (mpar == 0) rowA[mcol] = sv;
        else           rowB[mcol] = sv;
        if (mpar == 1 && (mcol % 2) == 1) begin
            exp_val = 1'b1;
            exp_res = max2(max2(rowA[mcol-1], rowA[mcol]), max2(rowB[mcol-1], rowB[mcol]));
        end
        if (mcol == mW - 1) begin
            mcol = 0;
            mpar = 1 - mpar;
        end else begin
            mcol++;
        end
    endtask

    task automatic step(input logic iv, input int d, input logic cv,
                        input int ca, input int cd);
        image     = d[15:0];
        image_val = iv;
        cfg_valid = cv;
        cfg_addr  = ca[4:0];
        cfg_data  = cd;
        model_update(iv, d, cv, ca, cd);
        @(posedge clk);
        #1;
        check("result_val", int'(result_val), int'(exp_val));
        check("result", int'(result), exp_res);
        if (result_val) dut_results++;
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic cfg_w(input int w);
        step(1'b0, 0, 1'b1, 1, w);
    endtask

    task automatic send(input int v);
        step(1'b1, v, 1'b0, 0, 0);
    endtask

    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_result_val", int'(result_val), 0);
        check("rst_result", int'(result), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int base;
        int w;
        rst = 1'b1;
        cfg_data = '0; cfg_addr = '0; cfg_valid = 1'b0;
        image = '0; image_val = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_result_val", int'(result_val), 0);
        check("reset_result", int'(result), 0);
        rst = 1'b0;

        // Basic 2x2 pooling with positive values.
        cfg_w(4);
        base = dut_results;
        for (int i = 1; i <= 5; i++) send(i * 256);
        send(6 * 256);
        check("r036_first_val", int'(result_val), 1);
        check("r036_first", int'(result), 6 * 256);
        send(7 * 256);
        send(8 * 256);
        check("r036_second", int'(result), 8 * 256);
        idle();
        check("r036_count", dut_results - base, 2);

        // Signed compare with negatives and a fraction.
        cfg_w(4);
        base = dut_results;
        send(-256); send(-512); send(-768); send(-1024);
        send(-1280); send(-1536);
        check("r037_first", int'(result), -256);
        send(-1792); send(-128);
        check("r037_second", int'(result), -128);
        check("r037_count", dut_results - base, 2);

        // Odd width: trailing column dropped.
        cfg_w(5);
        base = dut_results;
        for (int i = 1; i <= 10; i++) send(i * 256);
        idle();
        check("r038_count", dut_results - base, 2);
        check("r038_last", int'(result), 9 * 256);

        // Gapped input stream.
        cfg_w(4);
        base = dut_results;
        for (int i = 1; i <= 8; i++) begin
            idle();
            send(i * 256);
            if (i == 6) check("r039_first", int'(result), 6 * 256);
        end
        check("r039_second", int'(result), 8 * 256);
        check("r039_count", dut_results - base, 2);

        // Width write concurrent with a sample restarts pooling.
        cfg_w(4);
        for (int i = 1; i <= 6; i++) send(i * 256);
        base = dut_results;
        step(1'b1, 99 * 256, 1'b1, 1, 4);
        for (int i = 11; i <= 18; i++) send(i * 256);
        check("r040_count", dut_results - base, 2);
        check("r040_last", int'(result), 18 * 256);

        // Reset mid ODD row.
        cfg_w(4);
        for (int i = 1; i <= 6; i++) send(i * 256);
        pulse_reset();
        base = dut_results;
        for (int i = 1; i <= 8; i++) send(i * 256);
        check("r041_silent", dut_results - base, 0);
        cfg_w(4);
        for (int i = 1; i <= 8; i++) send(i * 256);
        check("r041_again", int'(result), 8 * 256);
        check("r041_count", dut_results - base, 2);

        // Widths below 2 discard input.
        for (int k = 0; k < 2; k++) begin
            cfg_w(k);
            base = dut_results;
            for (int i = 0; i < 10; i++) send(int'($urandom));
            check("narrow_count", dut_results - base, 0);
        end

        // Width saturation, with junk in the upper config bits.
        cfg_w(32'hABC0_012C);
        base = dut_results;
        for (int i = 0; i < 520; i++) send(int'($urandom));
        check("sat_count", dut_results - base, 128);

        // Random widths, gaps and writes to non-width addresses.
        for (int it = 0; it < 5; it++) begin
            w = int'($urandom_range(2, 9));
            cfg_w(w);
            for (int i = 0; i < 80; i++) begin
                logic iv;
                logic cv;
                int ca;
                iv = ($urandom_range(0, 3) != 0);
                cv = ($urandom_range(0, 15) == 0);
                ca = cv ? ((($urandom_range(0, 1)) != 0) ? int'($urandom_range(2, 3))
                                                         : int'($urandom_range(4, 31))) : 0;
                step(iv, int'($urandom), cv, ca, int'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_pool.md
STREAM_POOL -- requirements
Module: stream_pool

Interface
REQ-001 SHALL have parameter CFG_DWIDTH, default 32: config data bus width.
REQ-002 SHALL have parameter CFG_AWIDTH, default 5: config address width.
REQ-003 SHALL have parameter MEM_AWIDTH, default 8: line-memory address width.
REQ-004 SHALL have parameter MEM_DEPTH, default 128: line-memory entries; maximum row width is 2*MEM_DEPTH.
REQ-005 SHALL have parameter IMG_WIDTH, default 16: signed fixed-point sample width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port cfg_data, input, CFG_DWIDTH bits: configuration word.
REQ-009 SHALL have port cfg_addr, input, CFG_AWIDTH bits: configuration register select.
REQ-010 SHALL have port cfg_valid, input, 1 bit: config write strobe.
REQ-011 SHALL have port image, input, IMG_WIDTH bits: signed input sample, raster order (the filtered stream).
REQ-012 SHALL have port image_val, input, 1 bit: image qualifier; no backpressure.
REQ-013 SHALL have port result, output, IMG_WIDTH bits: signed 2x2 max-pooled sample.
REQ-014 SHALL have port result_val, output, 1 bit: result qualifier, one-cycle pulse per result.

Function
REQ-015 SHALL implement 2x2 max pooling, stride 2, over a raster stream of configured row width W.
REQ-016 SHALL latch W from cfg_data[MEM_AWIDTH:0] when cfg_valid=1 and cfg_addr=CFG_WIDTH (1); it SHALL ignore all other addresses (CFG_KERNEL=2, CFG_RESCALE=3, others).
REQ-017 SHALL saturate W values above 2*MEM_DEPTH to 2*MEM_DEPTH.
REQ-018 SHALL consume and discard all input while W<2, and SHALL emit no results in that state.
REQ-019 SHALL clear the column counter and the row-parity state on every CFG_WIDTH write; an image sample arriving in the same cycle as that write SHALL be discarded.
REQ-020 SHALL use two states: EVEN (row-parity 0) and ODD (row-parity 1); start in EVEN.
REQ-021 In EVEN, for each horizontal pair (col 2k, 2k+1), SHALL write the signed max of the pair to line memory entry k.
REQ-022 In ODD, SHALL read entry k at col 2k and compute the signed max of that entry and both current pixels at col 2k+1.
REQ-023 SHALL register the ODD-row result: result_val=1 exactly one clk after the image_val cycle carrying col 2k+1 of an ODD row; latency 1.
REQ-024 Column counter SHALL advance only on accepted image_val; gaps in image_val SHALL not alter results or state.
REQ-025 For odd W, the last pixel of each row SHALL be consumed and discarded; it SHALL not be written or compared.
REQ-026 At col W-1, the column counter SHALL wrap to 0 and the state SHALL toggle EVEN<->ODD.
REQ-027 Comparisons SHALL be two's-complement signed; on a tie either operand may be output, since the values are identical.
REQ-028 result SHALL hold its last value while result_val=0.
REQ-029 Throughput: SHALL produce one result per four accepted samples; it SHALL accept image_val every cycle.

Reset
REQ-030 On rst=1, result SHALL be 0, result_val 0, W 0, column counter 0, state EVEN.
REQ-031 Reset SHALL take effect asynchronously, at any point including mid-row; line-memory contents need not be cleared.
REQ-032 After rst deasserts, no result SHALL be emitted until W is reconfigured and a full row pair has been received.

Structure
REQ-033 The shared config package SHALL hold the address constants CFG_WIDTH=1, CFG_KERNEL=2 and CFG_RESCALE=3, plus the EVEN/ODD state encoding.
REQ-034 The line memory SHALL be a sub-module stream_pool_mem: single-port, MEM_DEPTH x IMG_WIDTH, synchronous read with 1-cycle latency, write-enable.
REQ-035 Counters, FSM, compare and output registers SHALL live in stream_pool; target size 120-400 lines of RTL.

Verification
REQ-036 Bench SHALL cover: W=4; inputs 1,2,3,4 / 5,6,7,8 (integer values scaled by 256) -> two results 6.0, 8.0, each one cycle after the inputs 6 and 8 respectively.
REQ-037 Bench SHALL cover: W=4; rows -1,-2,-3,-4 / -5,-6,-7,-0.5 -> results -1.0, -0.5 (signed compare).
REQ-038 Bench SHALL cover: W=5; rows 1..5 / 6..10 -> results 7.0, 9.0 only; samples 5 and 10 produce no output.
REQ-039 Bench SHALL cover: W=4; image_val toggling every other cycle, same data as REQ-036 -> same results 6.0, 8.0, each one cycle after the completing sample.
REQ-040 Bench SHALL cover: W=4; after 6 samples, write CFG_WIDTH=4 concurrently with sample 7 -> sample 7 dropped; next 8 samples pool afresh from column 0.
REQ-041 Bench SHALL cover: rst pulsed mid-ODD-row -> result_val 0 immediately; no output until reconfigured; REQ-036 then passes.
